// File: rtl/rgmii_rx_framer_if.sv
// Byte stream leaving the RGMII receive framer: payload byte plus valid/last/error strobes.
// No backpressure; the sink must accept every valid_o cycle.
interface rgmii_rx_framer_if;
  logic [7:0] data_o;
  logic       valid_o;
  logic       last_o;
  logic       error_o;

  modport master (output data_o, valid_o, last_o, error_o);
  modport slave  (input  data_o, valid_o, last_o, error_o);
endinterface

// File: rtl/rgmii_rx_framer.sv
// RGMII receive framer: strips preamble/SFD and emits payload bytes with last/error marking.
// Optional feature macro RGMII_RX_INBAND_STATUS_EN enables in-band link/speed/duplex capture.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// idle_s   | between frames, waiting for preamble or SFD
// preamble | inside 0x55 run, waiting for SFD
// payload  | forwarding bytes through the one-byte hold register
// drop_s   | discarding the rest of a bad/oversize/interrupted frame
module rgmii_rx_framer #(
  parameter int max_len_p = 1522
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [3:0]        rxd_rise_i,
  input  logic [3:0]        rxd_fall_i,
  input  logic              rx_ctl_rise_i,
  input  logic              rx_ctl_fall_i,
  rgmii_rx_framer_if.master rx_out,
  output logic              link_up_o,
  output logic [1:0]        speed_o,
  output logic              full_duplex_o
);

  localparam int len_w_lp = $clog2(max_len_p + 1);
  localparam logic [len_w_lp-1:0] len_max_lp = len_w_lp'(max_len_p);

  typedef enum logic [1:0] {
    idle_s     = 2'd0,
    preamble_s = 2'd1,
    payload_s  = 2'd2,
    drop_s     = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [7:0]          s1_byte;
  logic                s1_dv;
  logic                s1_er;
  logic [7:0]          hold_byte;
  logic                held_v;
  logic                err_flag;
  logic [len_w_lp-1:0] len_cnt;

  logic [7:0] data_q;
  logic       valid_q;
  logic       last_q;
  logic       error_q;

  logic emit, emit_last, emit_err;
  logic hold_load, err_set, sfd_hit, len_inc;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_byte <= '0;
      s1_dv   <= 1'b0;
      s1_er   <= 1'b0;
    end else begin
      s1_byte <= {rxd_fall_i, rxd_rise_i};
      s1_dv   <= rx_ctl_rise_i;
      s1_er   <= rx_ctl_rise_i ^ rx_ctl_fall_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= drop_s;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      idle_s: begin
        if (s1_dv && !s1_er && s1_byte == 8'h55) begin
          state_nxt = preamble_s;
        end else if (s1_dv && !s1_er && s1_byte == 8'hD5) begin
          state_nxt = payload_s;
        end
      end
      preamble_s: begin
        if (!s1_dv) begin
          state_nxt = idle_s;
        end else if (s1_er) begin
          state_nxt = drop_s;
        end else if (s1_byte == 8'hD5) begin
          state_nxt = payload_s;
        end else if (s1_byte != 8'h55) begin
          state_nxt = drop_s;
        end
      end
      payload_s: begin
        if (!s1_dv) begin
          state_nxt = idle_s;
        end else if (len_cnt == len_max_lp) begin
          state_nxt = drop_s;
        end
      end
      drop_s: begin
        if (!s1_dv) begin
          state_nxt = idle_s;
        end
      end
      default: state_nxt = drop_s;
    endcase
  end

  // Output decode; a byte leaves only once its successor (or dv fall) shows whether it is last.
  always_comb begin
    emit      = 1'b0;
    emit_last = 1'b0;
    emit_err  = 1'b0;
    hold_load = 1'b0;
    err_set   = 1'b0;
    len_inc   = 1'b0;
    sfd_hit   = 1'b0;
    case (state)
      idle_s, preamble_s: begin
        sfd_hit = s1_dv && !s1_er && s1_byte == 8'hD5;
      end
      payload_s: begin
        if (!s1_dv) begin
          emit      = held_v;
          emit_last = held_v;
          emit_err  = held_v && err_flag;
        end else if (len_cnt == len_max_lp) begin
          emit      = held_v;
          emit_last = held_v;
          emit_err  = held_v;
        end else begin
          emit      = held_v;
          hold_load = 1'b1;
          len_inc   = 1'b1;
          err_set   = s1_er;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hold_byte <= '0;
      held_v    <= 1'b0;
      err_flag  <= 1'b0;
      len_cnt   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      valid_q <= emit;
      last_q  <= emit_last;
      error_q <= emit_err;
      if (emit) begin
        data_q <= hold_byte;
      end
      if (sfd_hit) begin
        held_v   <= 1'b0;
        err_flag <= 1'b0;
        len_cnt  <= '0;
      end else begin
        if (hold_load) begin
          hold_byte <= s1_byte;
          held_v    <= 1'b1;
        end
        if (err_set) begin
          err_flag <= 1'b1;
        end
        if (len_inc && len_cnt != '1) begin
          len_cnt <= len_cnt + 1'b1;
        end
      end
    end
  end

  assign rx_out.data_o  = data_q;
  assign rx_out.valid_o = valid_q;
  assign rx_out.last_o  = last_q;
  assign rx_out.error_o = error_q;

`ifdef RGMII_RX_INBAND_STATUS_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      link_up_o     <= 1'b0;
      speed_o       <= 2'b00;
      full_duplex_o <= 1'b0;
    end else if (state == idle_s && !s1_dv && !s1_er) begin
      link_up_o     <= s1_byte[0];
      speed_o       <= s1_byte[2:1];
      full_duplex_o <= s1_byte[3];
    end
  end
`else
  // Fixed 1G full-duplex link; forced low only while reset is held.
  assign link_up_o     = reset_n_i;
  assign speed_o       = {reset_n_i, 1'b0};
  assign full_duplex_o = reset_n_i;
`endif

endmodule

// File: tb/tb_rgmii_rx_framer.sv
// Directed self-checking bench for rgmii_rx_framer.
// One step = drive inputs after a falling edge, clock once, sample outputs on the next falling edge.
module tb_rgmii_rx_framer;

  logic       clk_i;
  logic       reset_n_i;
  logic [3:0] rxd_rise_i;
  logic [3:0] rxd_fall_i;
  logic       rx_ctl_rise_i;
  logic       rx_ctl_fall_i;
  logic       link_up_o;
  logic [1:0] speed_o;
  logic       full_duplex_o;

  rgmii_rx_framer_if rx_if ();

  rgmii_rx_framer #(.max_len_p(1522)) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .rxd_rise_i    (rxd_rise_i),
    .rxd_fall_i    (rxd_fall_i),
    .rx_ctl_rise_i (rx_ctl_rise_i),
    .rx_ctl_fall_i (rx_ctl_fall_i),
    .rx_out        (rx_if),
    .link_up_o     (link_up_o),
    .speed_o       (speed_o),
    .full_duplex_o (full_duplex_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int checks = 0;
  int errors = 0;
  int step_n = 0;
  int stray  = 0;
  logic [7:0] q_data[$];
  bit         q_last[$];
  bit         q_err[$];
  int         q_step[$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] b, input logic dv, input logic er);
    rxd_rise_i    = b[3:0];
    rxd_fall_i    = b[7:4];
    rx_ctl_rise_i = dv;
    rx_ctl_fall_i = dv ^ er;
    @(posedge clk_i);
    @(negedge clk_i);
    step_n++;
    if (rx_if.valid_o) begin
      q_data.push_back(rx_if.data_o);
      q_last.push_back(rx_if.last_o);
      q_err.push_back(rx_if.error_o);
      q_step.push_back(step_n);
    end else if (rx_if.last_o || rx_if.error_o) begin
      stray++;
    end
  endtask

  task automatic clear_q();
    q_data.delete();
    q_last.delete();
    q_err.delete();
    q_step.delete();
  endtask

  // Payload byte k carries value k mod 256; er_at is the 0-based payload index flagged with RX_ER.
  task automatic run_frame(input string tag, input int npre, input int n_pay, input int er_at,
                           input int exp_n, input bit exp_err);
    int first;
    clear_q();
    for (int i = 0; i < npre; i++) step(8'h55, 1'b1, 1'b0);
    step(8'hD5, 1'b1, 1'b0);
    first = step_n + 1;
    for (int i = 0; i < n_pay; i++) step(8'(i), 1'b1, i == er_at);
    for (int i = 0; i < 6; i++) step(8'h00, 1'b0, 1'b0);
    chk({tag, " count"}, q_data.size(), exp_n);
    for (int k = 0; k < q_data.size(); k++) begin
      chk({tag, " data"}, int'(q_data[k]), k % 256);
      chk({tag, " last"}, int'(q_last[k]), int'(k == exp_n - 1));
      chk({tag, " err"}, int'(q_err[k]), int'(k == exp_n - 1 && exp_err));
    end
    // Byte sampled at edge s is on data_o after edge s+2, the third cycle.
    if (q_step.size() > 0) chk({tag, " latency"}, q_step[0], first + 2);
  endtask

  initial begin
    logic [7:0] tail [10];
    int pre_n;
    int lasts;

    reset_n_i = 1'b0;
    rxd_rise_i = '0;
    rxd_fall_i = '0;
    rx_ctl_rise_i = 1'b0;
    rx_ctl_fall_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst valid", int'(rx_if.valid_o), 0);
    chk("rst data", int'(rx_if.data_o), 0);
    chk("rst last", int'(rx_if.last_o), 0);
    chk("rst error", int'(rx_if.error_o), 0);
    chk("rst link", int'(link_up_o), 0);
    chk("rst speed", int'(speed_o), 0);
    chk("rst duplex", int'(full_duplex_o), 0);
    reset_n_i = 1'b1;
    for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) step(8'h0D, 1'b0, 1'b0);
    chk("inband link", int'(link_up_o), 1);
    chk("inband speed", int'(speed_o), 2);
    chk("inband duplex", int'(full_duplex_o), 1);

    run_frame("basic64", 7, 64, -1, 64, 1'b0);
    run_frame("er20", 7, 20, 9, 20, 1'b1);
    run_frame("zero", 7, 0, -1, 0, 1'b0);
    run_frame("one", 7, 1, -1, 1, 1'b0);
    run_frame("nopre", 0, 5, -1, 5, 1'b0);
    run_frame("oversize", 7, 1523, -1, 1522, 1'b1);

    clear_q();
    for (int i = 0; i < 7; i++) step(8'h55, 1'b1, 1'b0);
    step(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) step(8'(i), 1'b1, 1'b0);
    chk("midrst valid before", int'(rx_if.valid_o), 1);
    reset_n_i = 1'b0;
    #1;
    chk("midrst valid async", int'(rx_if.valid_o), 0);
    pre_n = q_data.size();
    chk("midrst pulses before", pre_n, 28);
    step(8'd30, 1'b1, 1'b0);
    step(8'd31, 1'b1, 1'b0);
    reset_n_i = 1'b1;
    for (int i = 32; i < 41; i++) step(8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(8'h00, 1'b0, 1'b0);
    chk("midrst pulses after", q_data.size(), pre_n);
    lasts = 0;
    foreach (q_last[k]) if (q_last[k]) lasts++;
    chk("midrst last", lasts, 0);
    run_frame("post_rst", 7, 16, -1, 16, 1'b0);

    clear_q();
    tail = '{8'hD5, 8'h55, 8'hD5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    step(8'h55, 1'b1, 1'b0);
    step(8'h55, 1'b1, 1'b0);
    step(8'h12, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(tail[i], 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(8'h00, 1'b0, 1'b0);
    chk("badpre pulses", q_data.size(), 0);

    chk("strobes without valid", stray, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
